// File: rtl/dmem_stall_unit.sv
// Data-memory stage behind a single-cycle datapath: a multi-cycle word array
// that stalls the requester until the access completes and flags misaligned accesses.
module dmem_stall_unit #(
  parameter int DEPTH   = 256,
  parameter int LATENCY = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        MemRead,
  input  logic        MemWrite,
  input  logic [31:0] Addr,
  input  logic [31:0] WriteData,
  output logic [31:0] ReadData,
  output logic        Stall,
  output logic        AddrErr,
  output logic        Busy
);

  localparam int IDX_W = $clog2(DEPTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t            state_r;
  state_t            state_nxt_s;
  logic [3:0]        cnt_r;
  logic              is_write_r;
  logic [IDX_W-1:0]  idx_r;
  logic [31:0]       wdata_r;
  logic [31:0]       mem_r [DEPTH];

  logic              req_s;
  logic              aligned_s;
  logic              accept_s;
  logic              misaligned_s;
  logic              finish_s;
  logic [IDX_W-1:0]  idx_s;
  logic              op_write_s;
  logic [IDX_W-1:0]  op_idx_s;
  logic [31:0]       op_data_s;
  logic              unused_addr_s;

  // Upper address bits only alias; they never select anything.
  assign unused_addr_s = ^{Addr[31:IDX_W+2]};

  // Request decode in the IDLE sampling cycle.
  always_comb begin
    req_s        = MemRead | MemWrite;
    aligned_s    = (Addr[1:0] == 2'b00);
    idx_s        = Addr[IDX_W+1:2];
    accept_s     = (state_r == IDLE) && req_s && aligned_s;
    misaligned_s = (state_r == IDLE) && req_s && !aligned_s;
  end

  // Operation source: live inputs on the accept cycle (needed when LATENCY=1), captured copy afterwards.
  always_comb begin
    if (state_r == IDLE) begin
      op_write_s = MemWrite;
      op_idx_s   = idx_s;
      op_data_s  = WriteData;
    end else begin
      op_write_s = is_write_r;
      op_idx_s   = idx_r;
      op_data_s  = wdata_r;
    end
  end

  // Next-state decode.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (accept_s) begin
          state_nxt_s = (LATENCY > 1) ? BUSY : DONE;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      BUSY: begin
        if (cnt_r == 4'd1) begin
          state_nxt_s = DONE;
        end else begin
          state_nxt_s = BUSY;
        end
      end
      DONE:    state_nxt_s = IDLE;
      default: state_nxt_s = IDLE;
    endcase
  end

  // Completion happens on the edge that enters DONE; Stall covers acceptance plus BUSY.
  always_comb begin
    finish_s = (state_nxt_s == DONE) && (state_r != DONE);
    Stall    = accept_s || (state_r == BUSY);
  end

  // Control FSM, capture registers and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= IDLE;
      cnt_r      <= 4'd0;
      is_write_r <= 1'b0;
      idx_r      <= '0;
      wdata_r    <= 32'd0;
      ReadData   <= 32'd0;
      AddrErr    <= 1'b0;
      Busy       <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      Busy    <= (state_nxt_s != IDLE);
      if (accept_s) begin
        is_write_r <= MemWrite;
        idx_r      <= idx_s;
        wdata_r    <= WriteData;
        cnt_r      <= 4'(LATENCY - 1);
      end else if (state_r == BUSY) begin
        cnt_r <= cnt_r - 4'd1;
      end else begin
        cnt_r <= cnt_r;
      end
      if (misaligned_s) begin
        AddrErr <= 1'b1;
      end
      if (finish_s) begin
        ReadData <= op_write_s ? op_data_s : mem_r[op_idx_s];
      end
    end
  end

  // Backing array; no reset so a reset mid-access simply drops the pending write.
  always_ff @(posedge clk) begin
    if (!rst && finish_s && op_write_s) begin
      mem_r[op_idx_s] <= op_data_s;
    end
  end

endmodule

// File: tb/tb_dmem_stall_unit.sv
// Directed bench for dmem_stall_unit: a LATENCY=3 instance for most scenarios
// and a LATENCY=1 instance for back-to-back accesses.
module tb_dmem_stall_unit;

  logic        clk;
  logic        rst, mem_read, mem_write;
  logic [31:0] addr, wdata, rdata;
  logic        stall, addr_err, busy;

  logic        rst1, mem_read1, mem_write1;
  logic [31:0] addr1, wdata1, rdata1;
  logic        stall1, addr_err1, busy1;

  int checks = 0;
  int errors = 0;

  dmem_stall_unit #(.DEPTH(256), .LATENCY(3)) dut (
    .clk(clk), .rst(rst), .MemRead(mem_read), .MemWrite(mem_write),
    .Addr(addr), .WriteData(wdata), .ReadData(rdata),
    .Stall(stall), .AddrErr(addr_err), .Busy(busy)
  );

  dmem_stall_unit #(.DEPTH(256), .LATENCY(1)) dut1 (
    .clk(clk), .rst(rst1), .MemRead(mem_read1), .MemWrite(mem_write1),
    .Addr(addr1), .WriteData(wdata1), .ReadData(rdata1),
    .Stall(stall1), .AddrErr(addr_err1), .Busy(busy1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Holds one request on the LATENCY=3 instance until Stall drops; reports the
  // stall count, ReadData/Busy in the completion cycle and Busy one cycle later.
  task automatic access(input logic rd, input logic wr, input logic [31:0] a,
                        input logic [31:0] d, output int stalls,
                        output logic [31:0] rd_done, output logic busy_done,
                        output logic busy_after);
    @(negedge clk);
    mem_read = rd; mem_write = wr; addr = a; wdata = d;
    stalls = 0;
    #1;
    while (stall === 1'b1 && stalls < 50) begin
      stalls++;
      @(negedge clk);
      #1;
    end
    rd_done = rdata;
    busy_done = busy;
    @(negedge clk);
    mem_read = 1'b0; mem_write = 1'b0;
    #1;
    busy_after = busy;
  endtask

  task automatic test_reset();
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    #1;
    checks++; if (rdata !== 32'h0) begin errors++; $display("FAIL reset_rdata: got %h expected 00000000", rdata); end
    checks++; if (addr_err !== 1'b0) begin errors++; $display("FAIL reset_addr_err: got %b expected 0", addr_err); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL reset_stall: got %b expected 0", stall); end
  endtask

  task automatic test_read_word0();
    int s; logic [31:0] r; logic bd, ba;
    access(1'b1, 1'b0, 32'h0, 32'h0, s, r, bd, ba);
    checks++; if (s !== 3) begin errors++; $display("FAIL read0_stalls: got %0d expected 3", s); end
    checks++; if (r !== 32'h0) begin errors++; $display("FAIL read0_rdata: got %h expected 00000000", r); end
    checks++; if (bd !== 1'b1) begin errors++; $display("FAIL read0_busy_done: got %b expected 1", bd); end
    checks++; if (ba !== 1'b0) begin errors++; $display("FAIL read0_busy_after: got %b expected 0", ba); end
  endtask

  task automatic test_write_read();
    int s; logic [31:0] r; logic bd, ba;
    access(1'b0, 1'b1, 32'h10, 32'hDEADBEEF, s, r, bd, ba);
    checks++; if (s !== 3) begin errors++; $display("FAIL wr10_stalls: got %0d expected 3", s); end
    checks++; if (r !== 32'hDEADBEEF) begin errors++; $display("FAIL wr10_rdata: got %h expected deadbeef", r); end
    access(1'b1, 1'b0, 32'h10, 32'h0, s, r, bd, ba);
    checks++; if (s !== 3) begin errors++; $display("FAIL rd10_stalls: got %0d expected 3", s); end
    checks++; if (r !== 32'hDEADBEEF) begin errors++; $display("FAIL rd10_rdata: got %h expected deadbeef", r); end
    access(1'b1, 1'b0, 32'h10 + 32'd1024, 32'h0, s, r, bd, ba);
    checks++; if (r !== 32'hDEADBEEF) begin errors++; $display("FAIL rd_alias_rdata: got %h expected deadbeef", r); end
  endtask

  task automatic test_misaligned();
    int s; logic [31:0] r; logic bd, ba;
    @(negedge clk); mem_read = 1'b1; addr = 32'h13;
    #1;
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL mis_stall: got %b expected 0", stall); end
    @(negedge clk); mem_read = 1'b0; mem_write = 1'b1; addr = 32'h11; wdata = 32'h0;
    #1;
    checks++; if (addr_err !== 1'b1) begin errors++; $display("FAIL mis_addr_err: got %b expected 1", addr_err); end
    checks++; if (rdata !== 32'hDEADBEEF) begin errors++; $display("FAIL mis_rdata: got %h expected deadbeef", rdata); end
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL mis_wr_stall: got %b expected 0", stall); end
    @(negedge clk); mem_write = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    checks++; if (addr_err !== 1'b1) begin errors++; $display("FAIL mis_addr_err_held: got %b expected 1", addr_err); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL mis_busy: got %b expected 0", busy); end
    access(1'b1, 1'b0, 32'h10, 32'h0, s, r, bd, ba);
    checks++; if (s !== 3) begin errors++; $display("FAIL mis_after_stalls: got %0d expected 3", s); end
    checks++; if (r !== 32'hDEADBEEF) begin errors++; $display("FAIL mis_after_rdata: got %h expected deadbeef", r); end
  endtask

  task automatic test_read_write_both();
    int s; logic [31:0] r; logic bd, ba;
    access(1'b1, 1'b1, 32'h20, 32'h12345678, s, r, bd, ba);
    checks++; if (s !== 3) begin errors++; $display("FAIL both_stalls: got %0d expected 3", s); end
    checks++; if (r !== 32'h12345678) begin errors++; $display("FAIL both_rdata: got %h expected 12345678", r); end
    access(1'b1, 1'b0, 32'h10, 32'h0, s, r, bd, ba);
    access(1'b1, 1'b0, 32'h20, 32'h0, s, r, bd, ba);
    checks++; if (r !== 32'h12345678) begin errors++; $display("FAIL both_readback: got %h expected 12345678", r); end
  endtask

  task automatic test_reset_mid_access();
    int s; logic [31:0] r; logic bd, ba;
    @(negedge clk); mem_write = 1'b1; addr = 32'h40; wdata = 32'hAAAA5555;
    #1;
    checks++; if (stall !== 1'b1) begin errors++; $display("FAIL rmid_accept_stall: got %b expected 1", stall); end
    @(negedge clk); rst = 1'b1; mem_write = 1'b0;
    @(negedge clk); rst = 1'b0;
    #1;
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL rmid_stall: got %b expected 0", stall); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rmid_busy: got %b expected 0", busy); end
    repeat (4) @(negedge clk);
    access(1'b1, 1'b0, 32'h40, 32'h0, s, r, bd, ba);
    checks++; if (r !== 32'h11112222) begin errors++; $display("FAIL rmid_readback: got %h expected 11112222", r); end
  endtask

  task automatic write1(input logic [31:0] a, input logic [31:0] d);
    @(negedge clk); mem_write1 = 1'b1; addr1 = a; wdata1 = d;
    @(negedge clk);
    @(negedge clk); mem_write1 = 1'b0;
  endtask

  task automatic test_back_to_back();
    write1(32'h0, 32'h00000A0A);
    write1(32'h4, 32'h0000B0B0);
    @(negedge clk); mem_read1 = 1'b1; addr1 = 32'h0;
    #1;
    checks++; if (stall1 !== 1'b1) begin errors++; $display("FAIL b2b_stall0: got %b expected 1", stall1); end
    @(negedge clk); addr1 = 32'h4;
    #1;
    checks++; if (stall1 !== 1'b0) begin errors++; $display("FAIL b2b_done0_stall: got %b expected 0", stall1); end
    checks++; if (busy1 !== 1'b1) begin errors++; $display("FAIL b2b_done0_busy: got %b expected 1", busy1); end
    checks++; if (rdata1 !== 32'h00000A0A) begin errors++; $display("FAIL b2b_rdata0: got %h expected 00000a0a", rdata1); end
    @(negedge clk);
    #1;
    checks++; if (busy1 !== 1'b0) begin errors++; $display("FAIL b2b_idle_busy: got %b expected 0", busy1); end
    checks++; if (stall1 !== 1'b1) begin errors++; $display("FAIL b2b_stall1: got %b expected 1", stall1); end
    @(negedge clk);
    #1;
    checks++; if (stall1 !== 1'b0) begin errors++; $display("FAIL b2b_done1_stall: got %b expected 0", stall1); end
    checks++; if (rdata1 !== 32'h0000B0B0) begin errors++; $display("FAIL b2b_rdata1: got %h expected 0000b0b0", rdata1); end
    @(negedge clk); mem_read1 = 1'b0;
    #1;
    checks++; if (busy1 !== 1'b0 || stall1 !== 1'b0) begin errors++; $display("FAIL b2b_final_idle: got busy=%b stall=%b expected 0 0", busy1, stall1); end
  endtask

  initial begin
    int s; logic [31:0] r; logic bd, ba;
    rst = 1'b1; mem_read = 1'b0; mem_write = 1'b0; addr = 32'h0; wdata = 32'h0;
    rst1 = 1'b1; mem_read1 = 1'b0; mem_write1 = 1'b0; addr1 = 32'h0; wdata1 = 32'h0;
    repeat (3) @(negedge clk);
    rst = 1'b0; rst1 = 1'b0;
    access(1'b0, 1'b1, 32'h0, 32'h0, s, r, bd, ba);
    access(1'b0, 1'b1, 32'h40, 32'h11112222, s, r, bd, ba);
    test_reset();
    test_read_word0();
    test_write_read();
    test_misaligned();
    test_read_write_both();
    test_reset_mid_access();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
